// File: rtl/mul_pkg.sv
// Shared definitions for the multiply scheduler and the multiply control unit.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick import mul_pkg::*; #(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

    logic found_s;
    int   j_s;

    // Scan requesters starting from ptr and take the first active one.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        j_s     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j_s = (int'(ptr_i) + i) % N_REQ;
            if (!found_s && req_i[j_s]) begin
                found_s     = 1'b1;
                gnt_o[j_s]  = 1'b1;
                idx_o       = IW'(j_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// Round-robin scheduler sharing one multiply control unit/datapath between N_REQ
// requesters, with a WAIT timeout that aborts a hung datapath.
module mul_scheduler import mul_pkg::*; #(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [2*WIDTH-1:0]     result,
    output logic                   max_hit,
    output logic                   err,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_ready,
    input  logic [2*WIDTH-1:0]     mul_result,
    input  logic                   mul_max_hit
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               start_q, start_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               mh_q, mh_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [N_REQ-1:0]   pick_gnt_s;
    logic [IW-1:0]      pick_idx_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt_s),
        .idx_o (pick_idx_s)
    );

    // Next-state and registered-output logic for the four-state controller.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        start_d = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        mh_d    = mh_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gidx_d  = pick_idx_s;
                    gnt_d   = pick_gnt_s;
                    a_d     = req_a[int'(pick_idx_s)*WIDTH +: WIDTH];
                    b_d     = req_b[int'(pick_idx_s)*WIDTH +: WIDTH];
                    start_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion on the terminal-count edge still counts as success.
                if (mul_ready) begin
                    res_d   = mul_result;
                    mh_d    = mul_max_hit;
                    err_d   = 1'b0;
                    done_d  = gnt_q;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    mh_d    = 1'b0;
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? IW'(0) : gidx_q + IW'(1);
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            mh_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            mh_q    <= mh_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign result    = res_q;
    assign max_hit   = mh_q;
    assign err       = err_q;
    assign mul_start = start_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;

endmodule
